// File: rtl/somador_bist.sv
// Built-in self test for a 4-bit adder: LFSR-driven operands, result checking and error counting.
// Define SOMADOR_BIST_ERRLOG_EN to add first-failure capture ports (first_fail_a/b/y).
module somador_bist #(
    parameter int unsigned N_VECTORS   = 15,
    parameter logic [7:0]  SEED        = 8'hA5,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] resultado,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] vector_count
`ifdef SOMADOR_BIST_ERRLOG_EN
    ,
    output logic [3:0] first_fail_a,
    output logic [3:0] first_fail_b,
    output logic [4:0] first_fail_y
`endif
);

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;

    localparam logic [7:0] SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
    localparam logic [7:0] N_LAST    = 8'(N_VECTORS);

    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [3:0] num1_q, num1_d;
    logic [3:0] num2_q, num2_d;
    logic [4:0] expected_q, expected_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] err_count_q, err_count_d;
    logic [7:0] vector_count_q, vector_count_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       lfsr_fb;
    logic       launch;
`ifdef SOMADOR_BIST_ERRLOG_EN
    logic [3:0] ff_a_q, ff_a_d;
    logic [3:0] ff_b_q, ff_b_d;
    logic [4:0] ff_y_q, ff_y_d;
`endif

    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    // done/busy are registered one cycle after entering DONE, so start is still ignored there
    assign launch = start && ((state_q == IDLE) || (state_q == DONE && !busy_q));

    always_comb begin
        state_d        = state_q;
        lfsr_d         = lfsr_q;
        num1_d         = num1_q;
        num2_d         = num2_q;
        expected_d     = expected_q;
        wait_cnt_d     = wait_cnt_q;
        err_count_d    = err_count_q;
        vector_count_d = vector_count_q;
        busy_d         = busy_q;
        done_d         = done_q;
        pass_d         = pass_q;
`ifdef SOMADOR_BIST_ERRLOG_EN
        ff_a_d         = ff_a_q;
        ff_b_d         = ff_b_q;
        ff_y_d         = ff_y_q;
`endif
        case (state_q)
            IDLE: ;
            DRIVE: begin
                num1_d     = lfsr_q[3:0];
                num2_d     = lfsr_q[7:4];
                expected_d = {1'b0, lfsr_q[3:0]} + {1'b0, lfsr_q[7:4]};
                wait_cnt_d = WAIT_LOAD;
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            CHECK: begin
                if (resultado != expected_q) begin
                    if (err_count_q != 4'hF) begin
                        err_count_d = err_count_q + 4'd1;
                    end
`ifdef SOMADOR_BIST_ERRLOG_EN
                    if (err_count_q == 4'd0) begin
                        ff_a_d = num1_q;
                        ff_b_d = num2_q;
                        ff_y_d = resultado;
                    end
`endif
                end
                vector_count_d = vector_count_q + 8'd1;
                lfsr_d         = {lfsr_q[6:0], lfsr_fb};
                state_d        = (vector_count_d == N_LAST) ? DONE : DRIVE;
            end
            DONE: begin
                if (!done_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    pass_d = (err_count_q == 4'd0);
                end
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            lfsr_d         = SEED_EFF;
            err_count_d    = 4'd0;
            vector_count_d = 8'd0;
            busy_d         = 1'b1;
            done_d         = 1'b0;
            pass_d         = 1'b0;
            state_d        = DRIVE;
`ifdef SOMADOR_BIST_ERRLOG_EN
            ff_a_d         = 4'd0;
            ff_b_d         = 4'd0;
            ff_y_d         = 5'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            lfsr_q         <= SEED_EFF;
            num1_q         <= 4'd0;
            num2_q         <= 4'd0;
            expected_q     <= 5'd0;
            wait_cnt_q     <= 4'd0;
            err_count_q    <= 4'd0;
            vector_count_q <= 8'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
`ifdef SOMADOR_BIST_ERRLOG_EN
            ff_a_q         <= 4'd0;
            ff_b_q         <= 4'd0;
            ff_y_q         <= 5'd0;
`endif
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            num1_q         <= num1_d;
            num2_q         <= num2_d;
            expected_q     <= expected_d;
            wait_cnt_q     <= wait_cnt_d;
            err_count_q    <= err_count_d;
            vector_count_q <= vector_count_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
`ifdef SOMADOR_BIST_ERRLOG_EN
            ff_a_q         <= ff_a_d;
            ff_b_q         <= ff_b_d;
            ff_y_q         <= ff_y_d;
`endif
        end
    end

    assign num1         = num1_q;
    assign num2         = num2_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign err_count    = err_count_q;
    assign vector_count = vector_count_q;
`ifdef SOMADOR_BIST_ERRLOG_EN
    assign first_fail_a = ff_a_q;
    assign first_fail_b = ff_b_q;
    assign first_fail_y = ff_y_q;
`endif

endmodule

// File: tb/tb_somador_bist.sv
// Directed self-checking bench for somador_bist: default instance plus an N_VECTORS=20, WAIT_CYCLES=3 instance.
module tb_somador_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start20;
    logic [4:0] resultado;
    logic [3:0] num1, num2, err_count;
    logic       busy, done, pass;
    logic [7:0] vector_count;
    logic [3:0] num1_20, num2_20, err_count_20;
    logic       busy_20, done_20, pass_20;
    logic [7:0] vector_count_20;
`ifdef SOMADOR_BIST_ERRLOG_EN
    logic [3:0] first_fail_a, first_fail_b, ff_a_20, ff_b_20;
    logic [4:0] first_fail_y, ff_y_20;
`endif

    int mode;
    int cyc;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    somador_bist dut (
        .clk(clk), .rst(rst), .start(start), .resultado(resultado),
        .num1(num1), .num2(num2), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .vector_count(vector_count)
`ifdef SOMADOR_BIST_ERRLOG_EN
        , .first_fail_a(first_fail_a), .first_fail_b(first_fail_b), .first_fail_y(first_fail_y)
`endif
    );

    somador_bist #(.N_VECTORS(20), .WAIT_CYCLES(3)) dut20 (
        .clk(clk), .rst(rst), .start(start20), .resultado(5'b00000),
        .num1(num1_20), .num2(num2_20), .busy(busy_20), .done(done_20), .pass(pass_20),
        .err_count(err_count_20), .vector_count(vector_count_20)
`ifdef SOMADOR_BIST_ERRLOG_EN
        , .first_fail_a(ff_a_20), .first_fail_b(ff_b_20), .first_fail_y(ff_y_20)
`endif
    );

    // adder under test: 0 = correct, 1 = stuck at zero, 2 = wrong LSB on the first vector only
    always_comb begin
        resultado = {1'b0, num1} + {1'b0, num2};
        if (mode == 1) begin
            resultado = 5'd0;
        end else if (mode == 2 && vector_count == 8'd0) begin
            resultado = resultado ^ 5'b00001;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // pulses start; returns at the falling edge just after the sampling edge with cyc cleared
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic waitDone(input string tag, input int exp_len);
        while (done !== 1'b1 && cyc < exp_len + 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput(tag, 32'(cyc), 32'(exp_len));
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        start20 = 1'b0;
        mode    = 0;
        cyc     = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset_num", {24'd0, num1, num2}, 32'h0);
        checkOutput("reset_flags", {29'd0, busy, done, pass}, 32'h0);
        checkOutput("reset_counts", {20'd0, err_count, vector_count}, 32'h0);
`ifdef SOMADOR_BIST_ERRLOG_EN
        checkOutput("reset_errlog", {19'd0, first_fail_a, first_fail_b, first_fail_y}, 32'h0);
`endif
        rst = 1'b0;

        $display("[TB] run with correct adder");
        applyStimulus();
        checkOutput("busy_after_start", 32'(busy), 32'h1);
        @(negedge clk); cyc++;
        checkOutput("vec1_drive", {24'd0, num1, num2}, 32'h5A);
        @(negedge clk); cyc++;
        checkOutput("vec1_hold", {24'd0, num1, num2}, 32'h5A);
        @(negedge clk); cyc++;
        checkOutput("vec1_counted", 32'(vector_count), 32'd1);
        @(negedge clk); cyc++;
        checkOutput("vec2_drive", {24'd0, num1, num2}, 32'hA4);
        repeat (3) begin @(negedge clk); cyc++; end
        checkOutput("vec3_drive", {24'd0, num1, num2}, 32'h59);
        repeat (3) begin @(negedge clk); cyc++; end
        checkOutput("vec4_drive", {24'd0, num1, num2}, 32'hA2);
        waitDone("run_len_good", 46);
        checkOutput("good_pass", {31'd0, pass}, 32'h1);
        checkOutput("good_busy", {31'd0, busy}, 32'h0);
        checkOutput("good_counts", {20'd0, err_count, vector_count}, {20'd0, 4'd0, 8'd15});
        repeat (3) @(negedge clk);
        checkOutput("done_holds", {23'd0, done, vector_count}, {23'd0, 1'b1, 8'd15});

        $display("[TB] restart from DONE with stuck-at-zero adder");
        mode = 1;
        applyStimulus();
        checkOutput("restart_done_clr", {30'd0, busy, done}, 32'h2);
        waitDone("run_len_stuck", 46);
        checkOutput("stuck_counts", {20'd0, err_count, vector_count}, {20'd0, 4'd15, 8'd15});
        checkOutput("stuck_pass", {31'd0, pass}, 32'h0);

        $display("[TB] reset in the middle of a run");
        applyStimulus();
        repeat (20) begin @(negedge clk); cyc++; end
        checkOutput("mid_counts", {20'd0, err_count, vector_count}, {20'd0, 4'd6, 8'd6});
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        checkOutput("rst_mid_flags", {29'd0, busy, done, pass}, 32'h0);
        checkOutput("rst_mid_state", {12'd0, num1, num2, err_count, vector_count}, 32'h0);
        mode = 0;
        applyStimulus();
        @(negedge clk); cyc++;
        checkOutput("after_rst_vec1", {24'd0, num1, num2}, 32'h5A);
        waitDone("run_len_after_rst", 46);
        checkOutput("after_rst_pass", {31'd0, pass}, 32'h1);

        $display("[TB] start held high during a run");
        applyStimulus();
        repeat (4) begin @(negedge clk); cyc++; end
        start = 1'b1;
        repeat (10) begin @(negedge clk); cyc++; end
        start = 1'b0;
        checkOutput("held_busy", {31'd0, busy}, 32'h1);
        checkOutput("held_no_restart", 32'(vector_count), 32'd4);
        waitDone("run_len_held", 46);

        $display("[TB] single mismatch on the first vector");
        mode = 2;
        applyStimulus();
        waitDone("run_len_onefail", 46);
        checkOutput("onefail_counts", {20'd0, err_count, vector_count}, {20'd0, 4'd1, 8'd15});
        checkOutput("onefail_pass", {31'd0, pass}, 32'h0);
`ifdef SOMADOR_BIST_ERRLOG_EN
        checkOutput("errlog_capture", {19'd0, first_fail_a, first_fail_b, first_fail_y},
                    {19'd0, 4'h5, 4'hA, 5'b01110});
`endif

        $display("[TB] N_VECTORS=20 WAIT_CYCLES=3 stuck-at-zero");
        @(negedge clk);
        start20 = 1'b1;
        @(negedge clk);
        start20 = 1'b0;
        cyc = 0;
        while (done_20 !== 1'b1 && cyc < 130) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("run_len_n20", 32'(cyc), 32'd101);
        checkOutput("n20_counts", {20'd0, err_count_20, vector_count_20}, {20'd0, 4'd15, 8'd20});
        checkOutput("n20_pass", {31'd0, pass_20}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/somador_bist.md
SOMADOR_BIST -- requirements
Module: somador_bist

Interface
REQ-001 Parameter N_VECTORS, default 15; number of vectors per run; legal range 1..255.
REQ-002 Parameter SEED, default 8'hA5; initial LFSR state; a value of 0 SHALL be replaced by 8'h01.
REQ-003 Parameter WAIT_CYCLES, default 1; settle cycles between driving operands and sampling resultado; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a run.
REQ-007 resultado  input  5  sum returned by the 4-bit adder under test.
REQ-008 num1  output  4  first operand driven to the adder.
REQ-009 num2  output  4  second operand driven to the adder.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high from run completion until the next start or rst.
REQ-012 pass  output  1  valid while done is high; 1 when err_count is 0.
REQ-013 err_count  output  4  number of mismatches; saturates at 15.
REQ-014 vector_count  output  8  number of vectors checked in the current run.

Function
REQ-015 FSM states SHALL be IDLE, DRIVE, WAIT, CHECK and DONE.
REQ-016 IDLE: start=1 SHALL do all of the following, then go to DRIVE:
- load the LFSR with SEED;
- clear err_count and vector_count;
- set busy=1.
REQ-017 DRIVE: one cycle. SHALL register num1=lfsr[3:0], num2=lfsr[7:4] and expected={1'b0,num1}+{1'b0,num2} (5-bit, no overflow loss); then go to WAIT.
REQ-018 WAIT: SHALL hold the operands for exactly WAIT_CYCLES cycles, then go to CHECK.
REQ-019 CHECK: one cycle. SHALL do all of the following:
- compare resultado with expected;
- on mismatch, increment err_count unless it is already 15;
- increment vector_count;
- advance the LFSR one step.
REQ-020 CHECK exit: if vector_count reaches N_VECTORS, go to DONE; otherwise go to DRIVE.
REQ-021 LFSR SHALL be an 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
REQ-022 Run duration: done SHALL rise exactly 1+N_VECTORS*(WAIT_CYCLES+2) cycles after the edge that samples start in IDLE.
REQ-023 DONE: busy=0, done=1, pass=(err_count==0). num1, num2, err_count and vector_count SHALL hold their values.
REQ-024 start=1 in DONE SHALL begin a new run exactly as in IDLE (same cycle count, done cleared).
REQ-025 start SHALL be ignored while busy=1.
REQ-026 num1 and num2 SHALL change only in DRIVE, so they are stable throughout WAIT and CHECK.

Reset
REQ-027 rst=1 SHALL force IDLE from any state, including mid-run, with priority over start.
REQ-028 On rst SHALL set num1=0, num2=0, busy=0, done=0, pass=0, err_count=0, vector_count=0 and LFSR=SEED.

Configuration
REQ-029 With macro SOMADOR_BIST_ERRLOG_EN defined, the block SHALL add outputs first_fail_a (4), first_fail_b (4) and first_fail_y (5):
- on the first mismatch of a run, capture num1, num2 and resultado;
- clear to 0 on rst and on run start;
- hold the captured values until then.
REQ-030 Without SOMADOR_BIST_ERRLOG_EN, those ports and the capture logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Correct adder (resultado=num1+num2), defaults, start pulse -> first DRIVE gives num1=4'h5, num2=4'hA, expected 5'b01111; done at cycle 46; pass=1; err_count=0; vector_count=15.
REQ-032 resultado stuck at 5'b00000, defaults -> done at cycle 46; err_count=15; pass=0. The LFSR never yields 0, so every expected sum is nonzero.
REQ-033 N_VECTORS=20, resultado stuck at 0 -> err_count saturates at 15; vector_count=20; pass=0.
REQ-034 rst pulse at cycle 20 of a run -> next cycle busy=0, done=0, all counts 0, num1=num2=0; a following start gives the same sequence as REQ-031.
REQ-035 start held high for 10 cycles during a run -> run length still 46 cycles; no restart.
REQ-036 SOMADOR_BIST_ERRLOG_EN defined, resultado=expected^5'b00001 on the first vector only -> first_fail_a=4'h5, first_fail_b=4'hA, first_fail_y=5'b01110; err_count=1; pass=0.
